// File: rtl/memory_ctrl_param.sv
// Parametrised registered single-port memory with request/acknowledge handshake.
// Accepts one access when idle, optionally waits WAIT_CYC cycles, then commits and pulses ack.
module memory_ctrl_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memrq,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              ready,
  output logic              ack,
  output logic              err,
  output logic [DATA_W-1:0] out_data
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rw_q, rw_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                finish_c;
  logic                in_range_c;
  logic                mem_we_c;
  logic [ADDR_W-1:0]   req_addr_c;
  logic [DATA_W-1:0]   req_data_c;
  logic                req_rw_c;
  logic [IDX_W-1:0]    idx_c;

  // With no wait cycles the commit happens on the accept edge, so use the live request
  always_comb begin
    req_addr_c = addr_q;
    req_data_c = wdata_q;
    req_rw_c   = rw_q;
    if (state_q == ST_IDLE) begin
      req_addr_c = addr;
      req_data_c = in_data;
      req_rw_c   = rw;
    end
    in_range_c = ({1'b0, req_addr_c} < (ADDR_W + 1)'(DEPTH));
    idx_c      = req_addr_c[IDX_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    finish_c = 1'b0;
    mem_we_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (memrq) begin
          addr_d  = addr;
          wdata_d = in_data;
          rw_d    = rw;
          if (WAIT_CYC == 0) begin
            state_d  = ST_DONE;
            finish_c = 1'b1;
          end else begin
            cnt_d   = CNT_W'(WAIT_CYC);
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = ST_DONE;
          finish_c = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Commit: out-of-range reads return zero and never touch the array
    if (finish_c) begin
      err_d = ~in_range_c;
      if (req_rw_c) begin
        rdata_d = in_range_c ? mem[idx_c] : '0;
      end else begin
        mem_we_c = in_range_c & ~rst;
      end
    end

    ready_d = (state_d == ST_IDLE);
    ack_d   = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= req_data_c;
    end
  end

  assign ready    = ready_q;
  assign ack      = ack_q;
  assign err      = err_q;
  assign out_data = rdata_q;

endmodule
